// File: rtl/execute_module.sv
// Execute stage: ALU/shifter, branch target adder, PSR, 256x32 write-first data memory.
// Define EXECUTE_ROTATE_EN to enable the rotate-right/rotate-left function codes.
module execute_module (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] PC_2,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  FS,
    input  logic [4:0]  SH,
    input  logic        MW,
    input  logic        PS,
    input  logic [1:0]  BS,
    input  logic        RW,
    input  logic [4:0]  DA,
    input  logic [1:0]  MD,
    output logic [3:0]  PSR,
    output logic        NxorV,
    output logic        Z,
    output logic        RW_1,
    output logic [4:0]  DA_1,
    output logic [1:0]  MD_1,
    output logic [31:0] BrA,
    output logic [31:0] RAA,
    output logic [31:0] FUNC_OUT_REG,
    output logic [31:0] DATA_OUT_REG,
    output logic [31:0] Bus_Dprime
);

    typedef enum logic [4:0] {
        FS_PASS_A   = 5'b00000,
        FS_INC      = 5'b00001,
        FS_ADD      = 5'b00010,
        FS_ADD_INC  = 5'b00011,
        FS_ADD_NOTB = 5'b00100,
        FS_SUB      = 5'b00101,
        FS_DEC      = 5'b00110,
        FS_AND      = 5'b01000,
        FS_OR       = 5'b01010,
        FS_XOR      = 5'b01100,
        FS_NOT      = 5'b01110,
        FS_PASS_B   = 5'b10000,
        FS_SLL      = 5'b10001,
        FS_SRL      = 5'b10010,
        FS_SRA      = 5'b10011,
        FS_ROR      = 5'b10100,
        FS_ROL      = 5'b10101
    } fs_e;

    fs_e         fs_op;
    logic [31:0] add_y;
    logic        add_cin;
    logic        add_sel;
    logic [32:0] sum;
    logic [31:0] f;
    logic        c;
    logic        v;
    logic        n;
    logic        z;

    logic [3:0]  psr_q,  psr_d;
    logic        rw_q,   rw_d;
    logic [4:0]  da_q,   da_d;
    logic [1:0]  md_q,   md_d;
    logic [31:0] func_q, func_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_q [256];

    logic        mem_we;
    logic [7:0]  addr;
    logic        unused_bs;

    assign fs_op     = fs_e'(FS);
    assign addr      = A[7:0];
    // BS is consumed by the branch unit downstream, not here.
    assign unused_bs = ^BS;

`ifdef EXECUTE_ROTATE_EN
    logic [31:0] ror_val;
    logic [31:0] rol_val;
    logic [5:0]  sh_inv;

    // Shift by 32 yields 0, so SH=0 degenerates cleanly to A.
    assign sh_inv  = 6'd32 - {1'b0, SH};
    assign ror_val = (A >> SH) | (A << sh_inv);
    assign rol_val = (A << SH) | (A >> sh_inv);
`endif

    // Adder operand selection: every arithmetic code is A + Y + cin.
    always_comb begin
        add_y   = '0;
        add_cin = 1'b0;
        add_sel = 1'b0;
        case (fs_op)
            FS_INC:      begin add_sel = 1'b1; add_cin = 1'b1; end
            FS_ADD:      begin add_sel = 1'b1; add_y = B; end
            FS_ADD_INC:  begin add_sel = 1'b1; add_y = B; add_cin = 1'b1; end
            FS_ADD_NOTB: begin add_sel = 1'b1; add_y = ~B; end
            FS_SUB:      begin add_sel = 1'b1; add_y = ~B; add_cin = 1'b1; end
            FS_DEC:      begin add_sel = 1'b1; add_y = '1; end
            default:     ;
        endcase
    end

    assign sum = {1'b0, A} + {1'b0, add_y} + {32'b0, add_cin};

    always_comb begin
        f = '0;
        c = 1'b0;
        v = 1'b0;
        if (add_sel) begin
            f = sum[31:0];
            c = sum[32];
            v = (A[31] == add_y[31]) && (sum[31] != A[31]);
        end else begin
            case (fs_op)
                FS_PASS_A: f = A;
                FS_AND:    f = A & B;
                FS_OR:     f = A | B;
                FS_XOR:    f = A ^ B;
                FS_NOT:    f = ~A;
                FS_PASS_B: f = B;
                FS_SLL:    f = A << SH;
                FS_SRL:    f = A >> SH;
                FS_SRA:    f = $signed(A) >>> SH;
`ifdef EXECUTE_ROTATE_EN
                FS_ROR:    f = ror_val;
                FS_ROL:    f = rol_val;
`endif
                default:   f = '0;
            endcase
        end
    end

    assign n = f[31];
    assign z = (f == '0);

    assign Bus_Dprime = f;
    assign Z          = z;
    assign NxorV      = n ^ v;
    assign BrA        = {16'b0, PC_2} + B;
    assign RAA        = A;

    assign mem_we = MW && !reset;

    always_comb begin
        psr_d  = PS ? {v, c, n, z} : psr_q;
        rw_d   = RW;
        da_d   = DA;
        md_d   = MD;
        func_d = f;
        data_d = MW ? B : mem_q[addr];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            psr_q  <= '0;
            rw_q   <= 1'b0;
            da_q   <= '0;
            md_q   <= '0;
            func_q <= '0;
            data_q <= '0;
        end else begin
            psr_q  <= psr_d;
            rw_q   <= rw_d;
            da_q   <= da_d;
            md_q   <= md_d;
            func_q <= func_d;
            data_q <= data_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[addr] <= B;
        end
    end

    assign PSR          = psr_q;
    assign RW_1         = rw_q;
    assign DA_1         = da_q;
    assign MD_1         = md_q;
    assign FUNC_OUT_REG = func_q;
    assign DATA_OUT_REG = data_q;

endmodule

// File: tb/tb_execute_module.sv
// Directed self-checking bench for execute_module; expected values are hand-computed.
module tb_execute_module;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] PC_2;
    logic [31:0] A, B;
    logic [4:0]  FS, SH;
    logic        MW, PS;
    logic [1:0]  BS;
    logic        RW;
    logic [4:0]  DA;
    logic [1:0]  MD;
    logic [3:0]  PSR;
    logic        NxorV, Z, RW_1;
    logic [4:0]  DA_1;
    logic [1:0]  MD_1;
    logic [31:0] BrA, RAA, FUNC_OUT_REG, DATA_OUT_REG, Bus_Dprime;

    int vectors = 0;
    int miscompares = 0;

    execute_module dut (
        .CLK(CLK), .reset(reset), .PC_2(PC_2), .A(A), .B(B), .FS(FS), .SH(SH),
        .MW(MW), .PS(PS), .BS(BS), .RW(RW), .DA(DA), .MD(MD),
        .PSR(PSR), .NxorV(NxorV), .Z(Z), .RW_1(RW_1), .DA_1(DA_1), .MD_1(MD_1),
        .BrA(BrA), .RAA(RAA), .FUNC_OUT_REG(FUNC_OUT_REG),
        .DATA_OUT_REG(DATA_OUT_REG), .Bus_Dprime(Bus_Dprime)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        reset = 1'b1; PC_2 = '0; A = '0; B = '0; FS = '0; SH = '0;
        MW = 1'b0; PS = 1'b0; BS = '0; RW = 1'b0; DA = '0; MD = '0;
        tick();
        tick();
        check("rst_psr",  {28'b0, PSR}, 32'h0);
        check("rst_rw1",  {31'b0, RW_1}, 32'h0);
        check("rst_da1",  {27'b0, DA_1}, 32'h0);
        check("rst_md1",  {30'b0, MD_1}, 32'h0);
        check("rst_func", FUNC_OUT_REG, 32'h0);
        check("rst_data", DATA_OUT_REG, 32'h0);

        // Add
        reset = 1'b0; RW = 1'b1; DA = 5'd9; MD = 2'd2; FS = 5'b00010; A = 32'd5; B = 32'd19;
        #1;
        check("add_f",   Bus_Dprime, 32'd24);
        check("add_z",   {31'b0, Z}, 32'd0);
        check("add_raa", RAA, 32'd5);
        tick();
        check("add_func", FUNC_OUT_REG, 32'd24);
        check("add_rw1",  {31'b0, RW_1}, 32'd1);
        check("add_da1",  {27'b0, DA_1}, 32'd9);
        check("add_md1",  {30'b0, MD_1}, 32'd2);
        check("add_psr_hold", {28'b0, PSR}, 32'h0);

        // AND giving zero
        RW = 1'b0; FS = 5'b01000; A = 32'd9; B = 32'd6;
        #1;
        check("and_f", Bus_Dprime, 32'd0);
        check("and_z", {31'b0, Z}, 32'd1);
        tick();
        check("and_func", FUNC_OUT_REG, 32'd0);
        check("and_rw1",  {31'b0, RW_1}, 32'd0);

        // Shifts
        FS = 5'b10010; SH = 5'd4; A = 32'h90;
        #1; check("srl", Bus_Dprime, 32'h9);
        FS = 5'b10011; A = 32'h8000_0000;
        #1; check("sra", Bus_Dprime, 32'hF800_0000);
        check("sra_nxv", {31'b0, NxorV}, 32'd1);
        FS = 5'b10001; SH = 5'd31; A = 32'h1;
        #1; check("sll31", Bus_Dprime, 32'h8000_0000);

        // Arithmetic variants
        FS = 5'b00101; A = 32'd3; B = 32'd5;
        #1; check("sub", Bus_Dprime, 32'hFFFF_FFFE);
        FS = 5'b00110; A = 32'd0;
        #1; check("dec0", Bus_Dprime, 32'hFFFF_FFFF);
        FS = 5'b00100; A = 32'd10; B = 32'd3;
        #1; check("add_notb", Bus_Dprime, 32'd6);
        FS = 5'b01110; A = 32'h0F0F_0000;
        #1; check("not", Bus_Dprime, 32'hF0F0_FFFF);

        // Undefined code and rotate codes
        FS = 5'b00111; A = 32'h1234; B = 32'h5678;
        #1; check("undef_f", Bus_Dprime, 32'h0);
        check("undef_z", {31'b0, Z}, 32'd1);
        FS = 5'b10100; SH = 5'd4; A = 32'h0000_00F1;
`ifdef EXECUTE_ROTATE_EN
        #1; check("ror", Bus_Dprime, 32'h1000_000F);
`else
        #1; check("ror_off", Bus_Dprime, 32'h0);
`endif

        // Memory write-first, then plain read
        FS = 5'b00000; MW = 1'b1; A = 32'd9; B = 32'h0000_FFFA;
        tick();
        check("mem_wfirst", DATA_OUT_REG, 32'h0000_FFFA);
        A = 32'd10; B = 32'h1234_5678;
        tick();
        MW = 1'b0; A = 32'd9; B = 32'd0;
        tick();
        check("mem_read9", DATA_OUT_REG, 32'h0000_FFFA);
        A = 32'd10;
        tick();
        check("mem_read10", DATA_OUT_REG, 32'h1234_5678);

        // Flags: overflow
        PS = 1'b1; FS = 5'b00010; A = 32'h7FFF_FFFF; B = 32'd1;
        #1;
        check("ovf_nxv", {31'b0, NxorV}, 32'd0);
        tick();
        check("ovf_psr", {28'b0, PSR}, 32'hA);
        // PS=0 holds PSR
        PS = 1'b0; FS = 5'b00101; A = 32'd0; B = 32'd0;
        tick();
        check("psr_hold", {28'b0, PSR}, 32'hA);
        // Carry out, zero result
        PS = 1'b1; FS = 5'b00010; A = 32'hFFFF_FFFF; B = 32'd1;
        tick();
        check("carry_psr", {28'b0, PSR}, 32'h5);
        PS = 1'b0;

        // Branch target
        PC_2 = 16'd1; B = 32'd19;
        #1; check("bra", BrA, 32'd20);
        PC_2 = 16'hFFFF; B = 32'hFFFF_FFFF;
        #1; check("bra_wrap", BrA, 32'h0000_FFFE);

        // Reset mid-sequence with a write attempt
        RW = 1'b1; DA = 5'd7; MD = 2'd3; FS = 5'b00000; A = 32'd9; B = 32'h0000_DEAD;
        tick();
        check("pre_rst_func", FUNC_OUT_REG, 32'd9);
        reset = 1'b1; MW = 1'b1; PS = 1'b1;
        #1; check("rst_comb", Bus_Dprime, 32'd9);
        tick();
        check("rst2_psr",  {28'b0, PSR}, 32'h0);
        check("rst2_rw1",  {31'b0, RW_1}, 32'h0);
        check("rst2_da1",  {27'b0, DA_1}, 32'h0);
        check("rst2_md1",  {30'b0, MD_1}, 32'h0);
        check("rst2_func", FUNC_OUT_REG, 32'h0);
        check("rst2_data", DATA_OUT_REG, 32'h0);
        reset = 1'b0; MW = 1'b0; PS = 1'b0;
        tick();
        check("mem_after_rst", DATA_OUT_REG, 32'h0000_FFFA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
